// File: rtl/rename_stage.sv
// rename_stage: renames up to WIDTH uops per cycle. A speculative map (RAT) and
// free list (SFREE) serve renaming. A committed map (CRAT) and free list (CFREE)
// follow retirement, and a flush restores the speculative state from them.
module rename_stage #(
  parameter int WIDTH     = 3,
  parameter int ARCH_REGS = 15,
  parameter int PHYS_REGS = 64,
  parameter int AW        = 4,
  parameter int TW        = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_dst_en,
  input  logic [WIDTH*AW-1:0]   in_dst,
  input  logic [3*WIDTH*AW-1:0] in_src,
  output logic [WIDTH-1:0]      out_valid,
  input  logic                  out_ready,
  output logic [WIDTH*TW-1:0]   out_dst_tag,
  output logic [WIDTH*TW-1:0]   out_old_tag,
  output logic [3*WIDTH*TW-1:0] out_src_tag,
  input  logic [WIDTH-1:0]      commit_valid,
  input  logic [WIDTH*AW-1:0]   commit_dst,
  input  logic [WIDTH*TW-1:0]   commit_tag,
  input  logic [WIDTH*TW-1:0]   commit_old,
  input  logic                  flush
);
  localparam int CW = $clog2(PHYS_REGS + 1);

  logic [ARCH_REGS-1:0][TW-1:0]  rat_q, rat_d, crat_q, crat_d;
  logic [PHYS_REGS-1:0]          sfree_q, sfree_d, cfree_q, cfree_d;
  logic [WIDTH-1:0]              out_valid_q, out_valid_d;
  logic [WIDTH-1:0][TW-1:0]      out_dst_q, out_dst_d, out_old_q, out_old_d;
  logic [WIDTH-1:0][2:0][TW-1:0] out_src_q, out_src_d;

  // Per-slot views of the flat buses; src k of slot s sits at (s*3+k)*AW.
  logic [WIDTH-1:0][AW-1:0]      dst_a, cdst_a;
  logic [WIDTH-1:0][2:0][AW-1:0] src_a;
  logic [WIDTH-1:0][TW-1:0]      ctag_a, cold_a;
  logic [WIDTH-1:0]              wr;     // slot writes an in-range destination
  logic [WIDTH-1:0][TW-1:0]      alloc, old_tag;
  logic [WIDTH-1:0][2:0][TW-1:0] src_tag;
  logic [CW-1:0]                 free_cnt;
  logic                          accept;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slot
    assign dst_a[gi]  = in_dst[gi*AW +: AW];
    assign src_a[gi]  = in_src[gi*3*AW +: 3*AW];
    assign cdst_a[gi] = commit_dst[gi*AW +: AW];
    assign ctag_a[gi] = commit_tag[gi*TW +: TW];
    assign cold_a[gi] = commit_old[gi*TW +: TW];
    assign wr[gi]     = in_valid[gi] & in_dst_en[gi] & (32'(dst_a[gi]) < ARCH_REGS);
  end

  // Count free speculative tags; a group is taken only if a full WIDTH is available.
  always_comb begin
    free_cnt = '0;
    for (int p = 0; p < PHYS_REGS; p++) free_cnt = free_cnt + CW'(sfree_q[p]);
  end

  assign in_ready = !flush && (32'(free_cnt) >= WIDTH) && ((out_valid_q == '0) || out_ready);
  assign accept   = (|in_valid) && in_ready;

  // Allocate lowest free tags oldest-first; resolve srcs and old tags through older slots.
  always_comb begin
    logic [PHYS_REGS-1:0] avail;
    logic found;
    avail   = sfree_q;
    alloc   = '0;
    old_tag = '0;
    src_tag = '0;
    found   = 1'b0;
    for (int s = 0; s < WIDTH; s++) begin
      found = 1'b0;
      if (wr[s]) begin
        for (int p = 0; p < PHYS_REGS; p++) begin
          if (!found && avail[p]) begin
            alloc[s] = TW'(p);
            avail[p] = 1'b0;
            found    = 1'b1;
          end
        end
        old_tag[s] = rat_q[dst_a[s]];
        // Ascending scan leaves the youngest older writer in place.
        for (int j = 0; j < WIDTH; j++)
          if (j < s && wr[j] && dst_a[j] == dst_a[s]) old_tag[s] = alloc[j];
      end
      for (int k = 0; k < 3; k++) begin
        if (32'(src_a[s][k]) < ARCH_REGS) begin
          src_tag[s][k] = rat_q[src_a[s][k]];
          for (int j = 0; j < WIDTH; j++)
            if (j < s && wr[j] && dst_a[j] == src_a[s][k]) src_tag[s][k] = alloc[j];
        end
      end
    end
  end

  // Next state: accept/drain the output stage, apply commits, then flush recovery.
  always_comb begin
    rat_d       = rat_q;
    crat_d      = crat_q;
    sfree_d     = sfree_q;
    cfree_d     = cfree_q;
    out_valid_d = out_valid_q;
    out_dst_d   = out_dst_q;
    out_old_d   = out_old_q;
    out_src_d   = out_src_q;
    if (accept) begin
      for (int s = 0; s < WIDTH; s++) begin
        if (wr[s]) begin
          rat_d[dst_a[s]]    = alloc[s];
          sfree_d[alloc[s]]  = 1'b0;
        end
      end
      out_valid_d = in_valid;
      out_dst_d   = alloc;
      out_old_d   = old_tag;
      out_src_d   = src_tag;
    end else if (out_ready) begin
      out_valid_d = '0;
    end
    // Commit-freed tags only reach sfree_q next cycle, so they allocate no earlier.
    for (int i = 0; i < WIDTH; i++) begin
      if (commit_valid[i]) begin
        if (32'(cdst_a[i]) < ARCH_REGS) crat_d[cdst_a[i]] = ctag_a[i];
        sfree_d[cold_a[i]] = 1'b1;
        cfree_d[cold_a[i]] = 1'b1;
        cfree_d[ctag_a[i]] = 1'b0;
      end
    end
    if (flush) begin
      rat_d       = crat_d;
      sfree_d     = cfree_d;
      out_valid_d = '0;
    end
  end

  // State registers; reset has priority over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat_q[i]  <= TW'(i);
        crat_q[i] <= TW'(i);
      end
      for (int p = 0; p < PHYS_REGS; p++) begin
        sfree_q[p] <= (p >= ARCH_REGS);
        cfree_q[p] <= (p >= ARCH_REGS);
      end
      out_valid_q <= '0;
      out_dst_q   <= '0;
      out_old_q   <= '0;
      out_src_q   <= '0;
    end else begin
      rat_q       <= rat_d;
      crat_q      <= crat_d;
      sfree_q     <= sfree_d;
      cfree_q     <= cfree_d;
      out_valid_q <= out_valid_d;
      out_dst_q   <= out_dst_d;
      out_old_q   <= out_old_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_dst_tag = out_dst_q;
  assign out_old_tag = out_old_q;
  assign out_src_tag = out_src_q;
endmodule

// File: tb/tb_rename_stage.sv
// tb_rename_stage: directed scenarios then random traffic, checked against a
// uop-by-uop renaming model (sequential map/free-list updates, ROB-style commit queue).
module tb_rename_stage;
  localparam int W = 3, A = 15, P = 64, AW = 4, TW = 6;

  logic clk = 1'b0;
  logic rst, flush, out_ready, in_ready;
  logic [W-1:0] in_valid, in_dst_en, out_valid, commit_valid;
  logic [W*AW-1:0] in_dst, commit_dst;
  logic [3*W*AW-1:0] in_src;
  logic [W*TW-1:0] out_dst_tag, out_old_tag, commit_tag, commit_old;
  logic [3*W*TW-1:0] out_src_tag;

  rename_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_dst_en(in_dst_en), .in_dst(in_dst), .in_src(in_src),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dst_tag(out_dst_tag), .out_old_tag(out_old_tag), .out_src_tag(out_src_tag),
    .commit_valid(commit_valid), .commit_dst(commit_dst),
    .commit_tag(commit_tag), .commit_old(commit_old), .flush(flush)
  );

  always #5 clk = ~clk;

  // Reference model state.
  typedef struct { int arch; int tag; int old; } ent_t;
  int     m_rat[A], m_crat[A];
  bit     m_sfree[P], m_cfree[P];
  logic [W-1:0] m_ov, m_mask;
  int     m_dst[W], m_old[W], m_src[W][3];
  ent_t   q[$];
  int     n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < A; i++) begin m_rat[i] = i; m_crat[i] = i; end
    for (int p = 0; p < P; p++) begin m_sfree[p] = (p >= A); m_cfree[p] = (p >= A); end
    m_ov = '0; m_mask = '1;
    for (int s = 0; s < W; s++) begin
      m_dst[s] = 0; m_old[s] = 0;
      for (int k = 0; k < 3; k++) m_src[s][k] = 0;
    end
    q.delete();
  endtask

  function automatic bit model_ready();
    int cnt;
    cnt = 0;
    for (int p = 0; p < P; p++) cnt += int'(m_sfree[p]);
    return !flush && cnt >= W && (m_ov == '0 || out_ready);
  endfunction

  // Rename uops one at a time in program order against a working copy of the map.
  task automatic model_step();
    bit acc;
    int map[A];
    bit fr[P];
    int d, si, nt, cd, ct, co;
    acc = (in_valid != '0) && model_ready();
    if (rst) begin model_reset(); return; end
    if (acc) begin
      map = m_rat; fr = m_sfree;
      for (int s = 0; s < W; s++) begin
        d = int'(in_dst[s*AW +: AW]);
        for (int k = 0; k < 3; k++) begin
          si = int'(in_src[(s*3+k)*AW +: AW]);
          m_src[s][k] = (si < A) ? map[si] : 0;
        end
        m_dst[s] = 0; m_old[s] = 0;
        if (in_valid[s] && in_dst_en[s] && d < A) begin
          nt = 0;
          for (int p = P - 1; p >= 0; p--) if (fr[p]) nt = p;
          fr[nt] = 1'b0;
          m_old[s] = map[d];
          map[d] = nt;
          m_dst[s] = nt;
          q.push_back('{arch: d, tag: nt, old: m_old[s]});
        end
      end
      m_rat = map; m_sfree = fr; m_ov = in_valid; m_mask = in_valid;
    end else if (out_ready) begin
      m_ov = '0;
    end
    for (int i = 0; i < W; i++) begin
      if (commit_valid[i]) begin
        cd = int'(commit_dst[i*AW +: AW]);
        ct = int'(commit_tag[i*TW +: TW]);
        co = int'(commit_old[i*TW +: TW]);
        if (cd < A) m_crat[cd] = ct;
        m_sfree[co] = 1'b1; m_cfree[co] = 1'b1; m_cfree[ct] = 1'b0;
      end
    end
    if (flush) begin
      m_rat = m_crat; m_sfree = m_cfree; m_ov = '0; q.delete();
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [W*TW-1:0] ed, eo;
    logic [3*W*TW-1:0] es, mk;
    ed = '0; eo = '0; es = '0; mk = '0;
    for (int s = 0; s < W; s++) begin
      ed[s*TW +: TW] = TW'(m_dst[s]);
      eo[s*TW +: TW] = TW'(m_old[s]);
      for (int k = 0; k < 3; k++) es[(s*3+k)*TW +: TW] = TW'(m_src[s][k]);
      if (m_mask[s]) mk[s*3*TW +: 3*TW] = '1;
    end
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_ov));
    chk({tag, ".dst_tag"}, 64'(out_dst_tag), 64'(ed));
    chk({tag, ".old_tag"}, 64'(out_old_tag), 64'(eo));
    chk({tag, ".src_tag"}, 64'(out_src_tag & mk), 64'(es & mk));
  endtask

  task automatic cycle(input string tag);
    #1;
    if (!rst) chk({tag, ".in_ready"}, 64'(in_ready), 64'(model_ready()));
    model_step();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic clear_in();
    rst = 1'b0; flush = 1'b0;
    in_valid = '0; in_dst_en = '0; in_dst = '0; in_src = '0;
    commit_valid = '0; commit_dst = '0; commit_tag = '0; commit_old = '0;
  endtask

  task automatic set_slot(input int s, input bit den, input int d, input int s0, input int s1, input int s2);
    in_valid[s] = 1'b1;
    in_dst_en[s] = den;
    in_dst[s*AW +: AW] = AW'(d);
    in_src[(s*3+0)*AW +: AW] = AW'(s0);
    in_src[(s*3+1)*AW +: AW] = AW'(s1);
    in_src[(s*3+2)*AW +: AW] = AW'(s2);
  endtask

  task automatic set_commit(input int i, input int d, input int t, input int o);
    commit_valid[i] = 1'b1;
    commit_dst[i*AW +: AW] = AW'(d);
    commit_tag[i*TW +: TW] = TW'(t);
    commit_old[i*TW +: TW] = TW'(o);
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    cycle("reset");
    rst = 1'b0;
  endtask

  initial begin
    ent_t e;
    out_ready = 1'b1;
    model_reset();
    do_reset();
    do_reset();

    // Single uop after reset: r1 <- r2.
    clear_in(); set_slot(0, 1, 1, 2, 0, 0); cycle("r32");
    chk("r32.dst", 64'(out_dst_tag[5:0]), 64'd15);
    chk("r32.old", 64'(out_old_tag[5:0]), 64'd1);
    chk("r32.src0", 64'(out_src_tag[5:0]), 64'd2);
    clear_in(); cycle("drain");

    // Intra-group dependency chain on r3.
    do_reset();
    clear_in();
    set_slot(0, 1, 3, 0, 0, 0);
    set_slot(1, 1, 3, 3, 0, 0);
    set_slot(2, 0, 0, 3, 0, 0);
    cycle("r33");
    chk("r33.s1.src", 64'(out_src_tag[3*TW +: TW]), 64'd15);
    chk("r33.s1.old", 64'(out_old_tag[TW +: TW]), 64'd15);
    chk("r33.s1.dst", 64'(out_dst_tag[TW +: TW]), 64'd16);
    chk("r33.s2.src", 64'(out_src_tag[6*TW +: TW]), 64'd16);
    chk("r33.s2.dst", 64'(out_dst_tag[2*TW +: TW]), 64'd0);

    // Backpressure: new group offered while the output is stalled.
    out_ready = 1'b0;
    clear_in(); set_slot(0, 1, 7, 1, 0, 0);
    for (int c = 0; c < 3; c++) cycle("r36.stall");
    chk("r36.held_dst", 64'(out_dst_tag[TW +: TW]), 64'd16);
    out_ready = 1'b1;
    cycle("r36.go");
    chk("r36.new_dst", 64'(out_dst_tag[5:0]), 64'd17);

    // Free-list exhaustion and commit-driven recovery.
    do_reset();
    for (int g = 0; g < 16; g++) begin
      clear_in();
      for (int s = 0; s < ((g < 15) ? 3 : 2); s++) set_slot(s, 1, (g*3 + s + 5) % A, 0, 0, 0);
      cycle("r34.fill");
    end
    clear_in(); set_commit(0, 5, 15, 5);
    #1; chk("r34.full_ready", 64'(in_ready), 64'd0);
    cycle("r34.commit");
    clear_in(); set_slot(0, 1, 1, 0, 0, 0);
    #1; chk("r34.ready_again", 64'(in_ready), 64'd1);
    cycle("r34.realloc");
    chk("r34.tag5", 64'(out_dst_tag[5:0]), 64'd5);

    // Commit then flush restores the committed view.
    do_reset();
    clear_in(); set_slot(0, 1, 4, 0, 0, 0); cycle("r35.a");
    clear_in(); set_slot(0, 1, 4, 0, 0, 0); cycle("r35.b");
    out_ready = 1'b0;
    clear_in(); set_commit(0, 4, 15, 4); cycle("r35.commit");
    clear_in(); flush = 1'b1; cycle("r35.flush");
    chk("r35.out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    clear_in(); set_slot(0, 1, 5, 4, 0, 0); set_slot(1, 1, 6, 0, 0, 0); cycle("r35.after");
    chk("r35.rat4", 64'(out_src_tag[5:0]), 64'd15);
    chk("r35.tag4", 64'(out_dst_tag[5:0]), 64'd4);
    chk("r35.tag16", 64'(out_dst_tag[TW +: TW]), 64'd16);

    // Reset overrides flush, commit and a pending full group.
    clear_in();
    set_slot(0, 1, 1, 0, 0, 0); set_slot(1, 1, 2, 0, 0, 0); set_slot(2, 1, 3, 0, 0, 0);
    cycle("r37.fill");
    chk("r37.ov", 64'(out_valid), 64'd7);
    out_ready = 1'b0;
    clear_in(); rst = 1'b1; flush = 1'b1; set_commit(0, 1, 16, 1);
    set_slot(0, 1, 2, 1, 0, 0);
    cycle("r37.rst");
    chk("r37.ov0", 64'(out_valid), 64'd0);
    chk("r37.src0", 64'(out_src_tag), 64'd0);
    out_ready = 1'b1;
    clear_in(); set_slot(0, 1, 1, 2, 0, 0);
    cycle("r37.after");
    chk("r37.dst", 64'(out_dst_tag[5:0]), 64'd15);
    chk("r37.old", 64'(out_old_tag[5:0]), 64'd1);

    // Random traffic with in-order commits of renamed writers.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      clear_in();
      for (int s = 0; s < W; s++) begin
        if ($urandom_range(0, 3) != 0)
          set_slot(s, $urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      end
      for (int i = 0; i < W; i++) begin
        if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
          e = q.pop_front();
          set_commit(i, e.arch, e.tag, e.old);
        end
      end
      flush = ($urandom_range(0, 24) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rename_stage.md
RENAME_STAGE -- requirements
Module: rename_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 3: uops renamed per cycle.
REQ-002 SHALL have parameter ARCH_REGS, default 15: architectural registers, indices 0..ARCH_REGS-1.
REQ-003 SHALL have parameter PHYS_REGS, default 64: physical registers; PHYS_REGS >= ARCH_REGS+WIDTH.
REQ-004 SHALL have parameters AW (default 4) and TW (default 6): arch-index and physical-tag widths.
REQ-005 SHALL have port clk, input, 1: clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port in_valid, input, WIDTH: per-slot uop valid; slot 0 is oldest.
REQ-008 SHALL have port in_ready, output, 1: group accepted when any in_valid bit is set and in_ready=1.
REQ-009 SHALL have port in_dst_en, input, WIDTH: slot writes a destination.
REQ-010 SHALL have ports in_dst, input, WIDTH*AW, and in_src, input, 3*WIDTH*AW: arch dst and src0..src2 per slot.
REQ-011 SHALL have port out_valid, output, WIDTH: registered per-slot valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts output.
REQ-013 SHALL have ports out_dst_tag and out_old_tag, output, WIDTH*TW each: new tag and previous mapping of dst.
REQ-014 SHALL have port out_src_tag, output, 3*WIDTH*TW: physical tags of src0..src2.
REQ-015 SHALL have ports commit_valid (input, WIDTH), commit_dst (input, WIDTH*AW), commit_tag and commit_old (input, WIDTH*TW each): retiring writers.
REQ-016 SHALL have port flush, input, 1: discard all speculative state.

Function
REQ-017 SHALL hold a speculative map RAT and a committed map CRAT, each ARCH_REGS entries of TW bits.
REQ-018 SHALL hold free bitmaps SFREE (speculative) and CFREE (committed), PHYS_REGS bits each.
REQ-019 SHALL allocate, per accepted slot with in_valid and in_dst_en, the lowest-numbered free SFREE tag not taken by an older slot in the same group.
REQ-020 SHALL map a src from the youngest older slot in the group with in_dst_en and an equal in_dst, else from RAT; out_old_tag is resolved the same way.
REQ-021 SHALL, on accept, update RAT with each written dst (youngest slot wins on equal dst) and clear allocated SFREE bits.
REQ-022 SHALL drive in_ready=1 only if flush=0, popcount(SFREE) >= WIDTH, and (out_valid==0 or out_ready=1).
REQ-023 SHALL register results with 1-cycle latency; outputs hold stable while out_valid!=0 and out_ready=0.
REQ-024 SHALL clear out_valid on out_ready=1 when no new group is accepted.
REQ-025 SHALL, per commit slot i ascending, set CRAT[commit_dst]=commit_tag, set SFREE[commit_old] and CFREE[commit_old], clear CFREE[commit_tag].
REQ-026 SHALL make commit-freed tags allocatable no earlier than the next cycle.
REQ-027 SHALL, on flush, load RAT from CRAT and SFREE from CFREE including same-cycle commits, clear out_valid, accept no group.
REQ-028 SHALL treat a dst index >= ARCH_REGS as in_dst_en=0 and output tag 0 for any src index >= ARCH_REGS.
REQ-029 SHALL output out_dst_tag=0 and out_old_tag=0 for slots without a valid destination.

Reset
REQ-030 SHALL on rst set RAT[i]=CRAT[i]=i, SFREE=CFREE=1 for tags ARCH_REGS..PHYS_REGS-1 and 0 otherwise, out_valid=0, all tag outputs 0.
REQ-031 SHALL give rst priority over flush, commit and accept, including mid-group with out_valid set.

Verification
REQ-032 SHALL cover: after reset, slot0 dst r1 src r2 -> next cycle out_dst_tag 15, out_old_tag 1, src0 tag 2.
REQ-033 SHALL cover: group slot0 dst r3, slot1 src r3 dst r3, slot2 src r3 -> slot1 src 15 old 15 dst 16, slot2 src 16.
REQ-034 SHALL cover: allocate until popcount(SFREE)=2 -> in_ready=0; one commit frees old tag 5 -> in_ready=1 the following cycle, tag 5 then allocatable.
REQ-035 SHALL cover: rename r4->15, r4->16, commit r4 tag 15 old 4, then flush -> RAT[4]=15, tag 16 free, tag 4 free, out_valid=0.
REQ-036 SHALL cover: out_ready=0 for 3 cycles with a new group offered -> outputs unchanged, in_ready=0, no tag consumed.
REQ-037 SHALL cover: rst asserted with out_valid=3'b111 and flush=1 -> reset state of REQ-030 next cycle.
